// File: rtl/kip_packet_formatter_if.sv
// AXI-Stream bus carrying KIP beats with kernel routing sideband (tdest/tid).
// The router side leaves tdest/tid unused; the kernel side drives all fields.
interface kip_packet_formatter_if #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned USER_WIDTH = 64,
   parameter int unsigned DEST_WIDTH = 8
);
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tlast;
   logic [DEST_WIDTH-1:0] tdest;
   logic [DEST_WIDTH-1:0] tid;

   modport master (output tvalid, tdata, tkeep, tuser, tlast, tdest, tid, input tready);
   modport slave  (input tvalid, tdata, tkeep, tuser, tlast, tdest, tid, output tready);
endinterface

// File: rtl/kip_packet_formatter.sv
// Multi-beat KIP formatter: tags each packet with header dest/sender IDs and router tuser,
// output through a 2-entry skid buffer. Define KIP_FMT_DEST_CHECK_EN to drop/count bad dests.
module kip_packet_formatter #(
   parameter int unsigned DATA_WIDTH        = 512,
   parameter int unsigned KEEP_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned KIP_TUSER_WIDTH   = 64,
   parameter int unsigned TDEST_WIDTH       = 8,
   parameter int unsigned TID_OFFSET        = 0,
   parameter int unsigned SENDER_TID_OFFSET = 8,
   parameter int unsigned NUM_KERNELS       = 16
) (
   input  logic                          i_clk,
   input  logic                          i_ap_rst_n,
   kip_packet_formatter_if.slave         from_router,
   kip_packet_formatter_if.master        to_kernels,
   output logic [15:0]                   o_drop_count
);

`ifdef KIP_FMT_DEST_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
   typedef enum logic [1:0] {ST_HEAD, ST_BODY, ST_DROP} state_t;
`else
   localparam bit CHECK_EN = 1'b0;
   typedef enum logic [1:0] {ST_HEAD, ST_BODY} state_t;
`endif

   typedef struct packed {
      logic [DATA_WIDTH-1:0]      tdata;
      logic [KEEP_WIDTH-1:0]      tkeep;
      logic                       tlast;
      logic [TDEST_WIDTH-1:0]     tdest;
      logic [TDEST_WIDTH-1:0]     tid;
      logic [KIP_TUSER_WIDTH-1:0] tuser;
   } beat_t;

   state_t                     state_q, state_d;
   beat_t                      ent0_q, ent1_q, new_beat;
   logic                       vld0_q, vld1_q;
   logic                       rdy_q, rdy_d;
   logic [TDEST_WIDTH-1:0]     dest_q, sender_q;
   logic [KIP_TUSER_WIDTH-1:0] tuser_q;
   logic [15:0]                drop_cnt_q;
   logic [1:0]                 occ_q, occ_d;
   logic                       accept, pop, push, latch, drop_inc, dest_ok;
   logic [TDEST_WIDTH-1:0]     hdr_dest, hdr_sender;

   assign accept     = from_router.tvalid && rdy_q;
   assign pop        = vld0_q && to_kernels.tready;
   assign hdr_dest   = from_router.tdata[TID_OFFSET +: TDEST_WIDTH];
   assign hdr_sender = from_router.tdata[SENDER_TID_OFFSET +: TDEST_WIDTH];
   assign dest_ok    = !CHECK_EN || (32'(hdr_dest) < NUM_KERNELS);
   assign occ_q      = 2'(vld0_q) + 2'(vld1_q);

   // Packet parser: header beat carries fresh IDs, later beats reuse the latched ones
   always_comb begin
      state_d        = state_q;
      push           = 1'b0;
      latch          = 1'b0;
      drop_inc       = 1'b0;
      new_beat.tdata = from_router.tdata;
      new_beat.tkeep = from_router.tkeep;
      new_beat.tlast = from_router.tlast;
      new_beat.tdest = dest_q;
      new_beat.tid   = sender_q;
      new_beat.tuser = tuser_q;
      case (state_q)
         ST_HEAD: begin
            if (accept) begin
               latch          = 1'b1;
               new_beat.tdest = hdr_dest;
               new_beat.tid   = hdr_sender;
               new_beat.tuser = from_router.tuser;
               if (dest_ok) begin
                  push    = 1'b1;
                  state_d = from_router.tlast ? ST_HEAD : ST_BODY;
               end
`ifdef KIP_FMT_DEST_CHECK_EN
               else begin
                  drop_inc = 1'b1;
                  state_d  = from_router.tlast ? ST_HEAD : ST_DROP;
               end
`endif
            end
         end
         ST_BODY: begin
            if (accept) begin
               push = 1'b1;
               if (from_router.tlast) state_d = ST_HEAD;
            end
         end
`ifdef KIP_FMT_DEST_CHECK_EN
         ST_DROP: begin
            if (accept && from_router.tlast) state_d = ST_HEAD;
         end
`endif
         default: state_d = ST_HEAD;
      endcase
   end

   // Registered ready: room for one more beat after this edge, or discarding a packet
   always_comb begin
      occ_d = occ_q + 2'(push) - 2'(pop);
      rdy_d = (occ_d <= 2'd1);
`ifdef KIP_FMT_DEST_CHECK_EN
      if (state_d == ST_DROP) rdy_d = 1'b1;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_ap_rst_n) begin
         state_q    <= ST_HEAD;
         rdy_q      <= 1'b0;
         dest_q     <= '0;
         sender_q   <= '0;
         tuser_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         if (latch) begin
            dest_q   <= hdr_dest;
            sender_q <= hdr_sender;
            tuser_q  <= from_router.tuser;
         end
         if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   // Skid buffer: ent0 is always the head presented on to_kernels
   always_ff @(posedge i_clk) begin
      if (!i_ap_rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         vld0_q <= 1'b0;
         vld1_q <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!vld0_q) begin
                  ent0_q <= new_beat;
                  vld0_q <= 1'b1;
               end else begin
                  ent1_q <= new_beat;
                  vld1_q <= 1'b1;
               end
            end
            2'b01: begin
               if (vld1_q) begin
                  ent0_q <= ent1_q;
                  vld1_q <= 1'b0;
               end else begin
                  vld0_q <= 1'b0;
               end
            end
            2'b11: begin
               if (vld1_q) begin
                  ent0_q <= ent1_q;
                  ent1_q <= new_beat;
               end else begin
                  ent0_q <= new_beat;
               end
            end
            default: ;
         endcase
      end
   end

   assign from_router.tready = rdy_q;
   assign to_kernels.tvalid  = vld0_q;
   assign to_kernels.tdata   = ent0_q.tdata;
   assign to_kernels.tkeep   = ent0_q.tkeep;
   assign to_kernels.tlast   = ent0_q.tlast;
   assign to_kernels.tdest   = ent0_q.tdest;
   assign to_kernels.tid     = ent0_q.tid;
   assign to_kernels.tuser   = ent0_q.tuser;
   assign o_drop_count       = drop_cnt_q;

endmodule

// File: doc/kip_packet_formatter.md
# kip_packet_formatter

Parametrised successor to the single-beat local KIP formatter: accepts multi-beat AXI-Stream packets from the router, extracts destination and sender kernel IDs from the first (header) beat and holds them for every beat of the packet. Emits packets to the local kernel interconnect through a registered 2-entry skid buffer at full throughput. Optionally drops packets addressed to non-existent kernels and counts them. Sits between the router output and the kernel-side AXIS switch.

## Interface
- DATA_WIDTH, 512, tdata width in bits
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- KIP_TUSER_WIDTH, 64, router tuser: {src IP, src port}
- TDEST_WIDTH, 8, kernel ID width
- TID_OFFSET, 0, bit offset of destination kernel ID in header beat
- SENDER_TID_OFFSET, 8, bit offset of sender kernel ID in header beat
- NUM_KERNELS, 16, valid destination IDs are 0..NUM_KERNELS-1
- i_clk  in  1  clock; all logic on rising edge
- i_ap_rst_n  in  1  synchronous, active-low reset
- from_router_tvalid / tready  in / out  1  input handshake
- from_router_tdata  in  DATA_WIDTH
- from_router_tkeep  in  KEEP_WIDTH
- from_router_tuser  in  KIP_TUSER_WIDTH  source port/IP
- from_router_tlast  in  1
- to_kernels_tvalid / tready  out / in  1  output handshake
- to_kernels_tdata, to_kernels_tkeep, to_kernels_tlast  out  as input  beat passthrough
- to_kernels_tdest  out  TDEST_WIDTH  latched destination ID
- to_kernels_tid  out  TDEST_WIDTH  latched sender ID
- to_kernels_tuser  out  KIP_TUSER_WIDTH  latched router tuser
- o_drop_count  out  16  dropped-packet count (0 when macro absent)

## Operation
- FSM states: HEAD, BODY, DROP. Reset → HEAD.
- HEAD, beat accepted: dest = tdata[TID_OFFSET +: TDEST_WIDTH], sender = tdata[SENDER_TID_OFFSET +: TDEST_WIDTH]; latch dest, sender, tuser.
  - dest valid (or check disabled): push beat with fresh dest/sender/tuser; tlast=1 → HEAD, else → BODY.
  - dest invalid: beat not pushed; drop counter +1; tlast=1 → HEAD, else → DROP.
- BODY: each accepted beat pushed with latched dest/sender/tuser (input tuser ignored after header); tlast → HEAD.
- DROP: from_router_tready forced 1; beats discarded; tlast → HEAD.
- Header beat is forwarded unmodified in tdata (not stripped).
- Skid buffer: 2 entries {tdata, tkeep, tlast, tdest, tid, tuser}; FIFO order; output always from head entry register.
- o_drop_count saturates at 0xFFFF; never wraps.

## Timing
- Reset values: to_kernels_tvalid 0, all to_kernels data/sideband 0, from_router_tready 0 during reset and 1 the cycle after release, o_drop_count 0, buffer empty.
- Latency: beat accepted at edge N is valid on to_kernels after edge N (visible cycle N+1).
- from_router_tready registered: 1 when buffer holds ≤1 entry after current edge, or state is DROP (or HEAD header that will drop is still only accepted when tready=1).
- Sustained throughput 1 beat/cycle with to_kernels_tready held 1.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Output backpressure: to_kernels_* held stable while tvalid=1 and tready=0.
- Single-beat packet (tlast on header): FSM stays HEAD; next beat is a header.
- Reset mid-packet: buffer flushed, FSM → HEAD, next accepted beat parsed as header; partial packet not completed.

## Configuration
- KIP_FMT_DEST_CHECK_EN defined: range check, DROP state and saturating o_drop_count as above.
- Undefined: every packet forwarded, dest taken as-is (no range check), DROP state absent, o_drop_count tied to 0.

## Test plan
- Single beat, tdata[7:0]=0x05, [15:8]=0x0A, tuser=0xABABCDCDEFEFEFEF, tlast=1, tready=1 → one output cycle later: tdest=0x05, tid=0x0A, tuser echoed, tlast=1, tdata/tkeep unchanged.
- 4-beat packet, header dest 0x03, beats 2–4 carry dest field 0xFE and tuser 0x1212…: all 4 outputs tdest=0x03, tuser = header tuser; back-to-back, no bubbles.
- to_kernels_tready low for 5 cycles mid-packet → tready to router drops after 2 buffered beats, outputs stable, no loss/duplication on release.
- With macro: 3-beat packet dest 0xFE (NUM_KERNELS=16) → no output, router tready=1 all 3 beats, o_drop_count 0→1; next valid packet forwarded normally. 65536+ drops → holds 0xFFFF.
- Without macro: dest 0xFE packet forwarded with tdest=0xFE; o_drop_count stays 0.
- Reset asserted after beat 2 of 4 → outputs to reset values; post-reset first beat parsed as header with its own dest.
